// File: rtl/n_clic_ctx_stack.sv
// Interrupt context stack: saves PC and nesting level on take, restores them on return,
// supports tail-chaining and latches a sticky fault on overflow, underflow or priority violation.
module n_clic_ctx_stack #(
  parameter int AddrWidth = 32,
  parameter int PrioWidth = 3,
  parameter int Depth     = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         int_take,
  input  logic [PrioWidth-1:0]         int_prio,
  input  logic [AddrWidth-1:0]         int_addr,
  input  logic [AddrWidth-1:0]         pc_next,
  input  logic                         ret,
  output logic [AddrWidth-1:0]         pc_out,
  output logic                         redirect,
  output logic [PrioWidth-1:0]         level_out,
  output logic [$clog2(Depth+1)-1:0]   depth_out,
  output logic                         fault
);

  localparam int SpWidth = $clog2(Depth + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t                 state_r, state_n;
  logic [SpWidth-1:0]     sp_r, sp_n;
  logic [PrioWidth-1:0]   cur_level_r, level_n;
  logic [AddrWidth-1:0]   saved_pc_r    [Depth];
  logic [PrioWidth-1:0]   saved_level_r [Depth];
  logic [SpWidth-1:0]     top_s;
  logic                   push_s;

  // Event decode: redirect target and next stack state from the current inputs
  always_comb begin
    state_n  = state_r;
    sp_n     = sp_r;
    level_n  = cur_level_r;
    push_s   = 1'b0;
    redirect = 1'b0;
    pc_out   = pc_next;
    top_s    = sp_r - {{(SpWidth-1){1'b0}}, 1'b1};
    if (reset) begin
      state_n = ST_RUN;
    end else if (state_r == ST_RUN) begin
      if (int_take && ret && (sp_r != '0)) begin
        // Tail-chain: the new handler must outrank the level being returned to
        if (int_prio > saved_level_r[top_s]) begin
          redirect = 1'b1;
          pc_out   = int_addr;
          level_n  = int_prio;
        end else begin
          state_n = ST_FAULT;
        end
      end else if (int_take) begin
        if ((int_prio > cur_level_r) && (sp_r < SpWidth'(Depth))) begin
          redirect = 1'b1;
          pc_out   = int_addr;
          level_n  = int_prio;
          push_s   = 1'b1;
          sp_n     = sp_r + {{(SpWidth-1){1'b0}}, 1'b1};
        end else begin
          state_n = ST_FAULT;
        end
      end else if (ret) begin
        if (sp_r != '0) begin
          redirect = 1'b1;
          pc_out   = saved_pc_r[top_s];
          level_n  = saved_level_r[top_s];
          sp_n     = top_s;
        end else begin
          state_n = ST_FAULT;
        end
      end else begin
        state_n = ST_RUN;
      end
    end else begin
      state_n = ST_FAULT;
    end
  end

  // Control state: FSM, stack pointer and current level
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      sp_r        <= '0;
      cur_level_r <= '0;
    end else begin
      state_r     <= state_n;
      sp_r        <= sp_n;
      cur_level_r <= level_n;
    end
  end

  // Stack storage; entries above sp are don't-care and never cleared
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      saved_pc_r[sp_r]    <= pc_next;
      saved_level_r[sp_r] <= cur_level_r;
    end
  end

  assign level_out = cur_level_r;
  assign depth_out = sp_r;
  assign fault     = (state_r == ST_FAULT);

endmodule

// File: tb/tb_n_clic_ctx_stack.sv
// Self-checking bench for n_clic_ctx_stack: directed scenarios plus randomized traffic
// against a queue-based reference model of the context stack.
module tb_n_clic_ctx_stack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        int_take = 1'b0;
  logic [2:0]  int_prio = 3'd0;
  logic [31:0] int_addr = 32'd0;
  logic [31:0] pc_next = 32'd0;
  logic        ret = 1'b0;
  logic [31:0] pc_out;
  logic        redirect;
  logic [2:0]  level_out;
  logic [2:0]  depth_out;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  int unsigned stk_pc[$];
  int unsigned stk_lv[$];
  int unsigned m_level = 0;
  bit          m_fault = 1'b0;
  bit          exp_red;
  int unsigned exp_pc;

  n_clic_ctx_stack dut (
    .clk(clk), .reset(reset), .int_take(int_take), .int_prio(int_prio),
    .int_addr(int_addr), .pc_next(pc_next), .ret(ret), .pc_out(pc_out),
    .redirect(redirect), .level_out(level_out), .depth_out(depth_out), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input bit t, input int unsigned p, input int unsigned a,
                                     input bit r, input int unsigned pcn);
    exp_red = 1'b0;
    exp_pc  = pcn;
    if (m_fault || (!t && !r)) return;
    if (t && r && stk_lv.size() > 0) begin
      if (p > stk_lv[stk_lv.size()-1]) begin
        exp_red = 1'b1; exp_pc = a; m_level = p;
      end else m_fault = 1'b1;
    end else if (t) begin
      if (p > m_level && stk_pc.size() < 7) begin
        stk_pc.push_back(pcn); stk_lv.push_back(m_level);
        exp_red = 1'b1; exp_pc = a; m_level = p;
      end else m_fault = 1'b1;
    end else begin
      if (stk_pc.size() > 0) begin
        exp_red = 1'b1; exp_pc = stk_pc.pop_back(); m_level = stk_lv.pop_back();
      end else m_fault = 1'b1;
    end
  endfunction

  task automatic apply(input bit t, input int unsigned p, input int unsigned a,
                       input bit r, input int unsigned pcn);
    int_take = t; int_prio = p[2:0]; int_addr = a; ret = r; pc_next = pcn;
    model_step(t, p, a, r, pcn);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    int_take = 1'b0; ret = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; int_take = 1'b1; int_prio = 3'd3; int_addr = 32'd8; pc_next = 32'd4;
    #1;
    n_cmp++;
    if (redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect: got %0b expected 0", redirect); end
    @(posedge clk); #1;
    reset = 1'b0; int_take = 1'b0; ret = 1'b0;
    stk_pc.delete(); stk_lv.delete(); m_level = 0; m_fault = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    n_cmp++;
    if (level_out !== 3'd0 || depth_out !== 3'd0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got level=%0d depth=%0d fault=%0b expected 0/0/0", level_out, depth_out, fault);
    end
    pc_next = 32'd123; #1;
    n_cmp++;
    if (redirect !== 1'b0 || pc_out !== 32'd123) begin
      n_bad++; $display("FAIL reset_idle: got red=%0b pc=%0d expected 0/123", redirect, pc_out);
    end
  endtask

  task automatic test_nested();
    do_reset();
    apply(1'b1, 1, 32, 1'b0, 100);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd32) begin n_bad++; $display("FAIL nest_take1: got red=%0b pc=%0d expected 1/32", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd1 || depth_out !== 3'd1) begin n_bad++; $display("FAIL nest_state1: got lvl=%0d dep=%0d expected 1/1", level_out, depth_out); end
    apply(1'b1, 2, 16, 1'b0, 40);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd16) begin n_bad++; $display("FAIL nest_take2: got red=%0b pc=%0d expected 1/16", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd2 || depth_out !== 3'd2) begin n_bad++; $display("FAIL nest_state2: got lvl=%0d dep=%0d expected 2/2", level_out, depth_out); end
    apply(1'b0, 0, 0, 1'b1, 77);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd40) begin n_bad++; $display("FAIL nest_ret1: got red=%0b pc=%0d expected 1/40", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd1 || depth_out !== 3'd1) begin n_bad++; $display("FAIL nest_state3: got lvl=%0d dep=%0d expected 1/1", level_out, depth_out); end
    apply(1'b0, 0, 0, 1'b1, 78);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd100) begin n_bad++; $display("FAIL nest_ret2: got red=%0b pc=%0d expected 1/100", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd0 || depth_out !== 3'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL nest_state4: got lvl=%0d dep=%0d flt=%0b expected 0/0/0", level_out, depth_out, fault); end
  endtask

  task automatic test_prio_violation();
    do_reset();
    apply(1'b1, 1, 32, 1'b0, 100); tick();
    apply(1'b1, 2, 16, 1'b0, 40);  tick();
    apply(1'b1, 2, 48, 1'b0, 60);
    n_cmp++;
    if (redirect !== 1'b0 || pc_out !== 32'd60) begin n_bad++; $display("FAIL prio_redirect: got red=%0b pc=%0d expected 0/60", redirect, pc_out); end
    tick();
    n_cmp++;
    if (fault !== 1'b1 || level_out !== 3'd2 || depth_out !== 3'd2) begin n_bad++; $display("FAIL prio_state: got flt=%0b lvl=%0d dep=%0d expected 1/2/2", fault, level_out, depth_out); end
    apply(1'b0, 0, 0, 1'b1, 64);
    n_cmp++;
    if (redirect !== 1'b0) begin n_bad++; $display("FAIL prio_ret_ignored: got red=%0b expected 0", redirect); end
    tick();
    n_cmp++;
    if (depth_out !== 3'd2 || fault !== 1'b1) begin n_bad++; $display("FAIL prio_frozen: got dep=%0d flt=%0b expected 2/1", depth_out, fault); end
  endtask

  task automatic test_tail_chain();
    do_reset();
    apply(1'b1, 1, 32, 1'b0, 100); tick();
    apply(1'b1, 4, 56, 1'b1, 36);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd56) begin n_bad++; $display("FAIL tail_redirect: got red=%0b pc=%0d expected 1/56", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd4 || depth_out !== 3'd1) begin n_bad++; $display("FAIL tail_state: got lvl=%0d dep=%0d expected 4/1", level_out, depth_out); end
    apply(1'b0, 0, 0, 1'b1, 60);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd100) begin n_bad++; $display("FAIL tail_ret: got red=%0b pc=%0d expected 1/100", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd0 || depth_out !== 3'd0) begin n_bad++; $display("FAIL tail_final: got lvl=%0d dep=%0d expected 0/0", level_out, depth_out); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      apply(1'b1, i, 200 + i, 1'b0, 300 + i);
      tick();
    end
    n_cmp++;
    if (depth_out !== 3'd7 || level_out !== 3'd7 || fault !== 1'b0) begin n_bad++; $display("FAIL ovf_full: got dep=%0d lvl=%0d flt=%0b expected 7/7/0", depth_out, level_out, fault); end
    apply(1'b1, 7, 400, 1'b0, 500);
    n_cmp++;
    if (redirect !== 1'b0) begin n_bad++; $display("FAIL ovf_redirect: got red=%0b expected 0", redirect); end
    tick();
    n_cmp++;
    if (fault !== 1'b1 || depth_out !== 3'd7) begin n_bad++; $display("FAIL ovf_state: got flt=%0b dep=%0d expected 1/7", fault, depth_out); end
  endtask

  task automatic test_underflow_recovery();
    do_reset();
    apply(1'b0, 0, 0, 1'b1, 20);
    n_cmp++;
    if (redirect !== 1'b0) begin n_bad++; $display("FAIL unf_redirect: got red=%0b expected 0", redirect); end
    tick();
    n_cmp++;
    if (fault !== 1'b1 || depth_out !== 3'd0) begin n_bad++; $display("FAIL unf_state: got flt=%0b dep=%0d expected 1/0", fault, depth_out); end
    do_reset();
    n_cmp++;
    if (fault !== 1'b0) begin n_bad++; $display("FAIL unf_reset: got flt=%0b expected 0", fault); end
    apply(1'b1, 1, 88, 1'b0, 24);
    n_cmp++;
    if (redirect !== 1'b1 || pc_out !== 32'd88) begin n_bad++; $display("FAIL unf_recover: got red=%0b pc=%0d expected 1/88", redirect, pc_out); end
    tick();
    n_cmp++;
    if (level_out !== 3'd1 || depth_out !== 3'd1) begin n_bad++; $display("FAIL unf_recover_state: got lvl=%0d dep=%0d expected 1/1", level_out, depth_out); end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        int unsigned sel;
        bit t, r;
        sel = $urandom_range(0, 9);
        t = (sel < 5) || (sel == 9);
        r = (sel >= 5 && sel < 8) || (sel == 9);
        apply(t, $urandom_range(0, 7), $urandom, r, $urandom);
        n_cmp++;
        if (redirect !== exp_red || pc_out !== exp_pc) begin
          n_bad++;
          $display("FAIL rnd_comb ep%0d c%0d: got red=%0b pc=%h expected %0b/%h", ep, c, redirect, pc_out, exp_red, exp_pc);
        end
        tick();
        n_cmp++;
        if (level_out !== m_level[2:0] || depth_out !== stk_pc.size() || fault !== m_fault) begin
          n_bad++;
          $display("FAIL rnd_state ep%0d c%0d: got lvl=%0d dep=%0d flt=%0b expected %0d/%0d/%0b",
                   ep, c, level_out, depth_out, fault, m_level, stk_pc.size(), m_fault);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nested();
    test_prio_violation();
    test_tail_chain();
    test_overflow();
    test_underflow_recovery();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
